// File: rtl/jesd207_pkg.sv
// Shared constants for the JESD207 transmit path: state codes common with the
// transmit controller, and the frame strobe levels for the I and Q slots.
package jesd207_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_RUN_I  = 3'd2;
  localparam logic [2:0] ST_RUN_Q  = 3'd3;
  localparam logic [2:0] ST_END    = 3'd4;

  localparam logic TX_FRAME_I = 1'b1;
  localparam logic TX_FRAME_Q = 1'b0;

  // state | meaning: IDLE wait start | SETTLE TXNRX delay | RUN_I I slot | RUN_Q Q slot | END drain
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_RUN_I  = ST_RUN_I,
    S_RUN_Q  = ST_RUN_Q,
    S_END    = ST_END
  } tx_state_e;

endpackage

// File: rtl/jesd207_tx_framer.sv
// JESD207 single-port CMOS SDR transmit framer: pops interleaved I/Q words from
// the sample FIFO and drives tx_data/tx_frame in bursts of whole I/Q pairs.
module jesd207_tx_framer
  import jesd207_pkg::*;
#(
  parameter int DW        = 12,
  parameter int CW        = 16,
  parameter int START_DLY = 2
) (
  input  logic          fclk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] burst_pairs,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_rempty,
  output logic          fifo_rinc,
  output logic [DW-1:0] tx_data,
  output logic          tx_frame,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam int DLYW     = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int DLY_INIT = (START_DLY > 0) ? START_DLY - 1 : 0;
  localparam logic [DLYW-1:0] DLY_LOAD = DLY_INIT[DLYW-1:0];

  tx_state_e       r_state;
  tx_state_e       w_state_nxt;
  logic [CW-1:0]   r_burst_pairs;
  logic [CW-1:0]   r_pair_cnt;
  logic [CW-1:0]   w_pair_cnt_inc;
  logic [DLYW-1:0] r_dly;
  logic            r_pend;
  logic            r_pend_i;
  logic            r_underrun;
  logic [DW-1:0]   r_tx_data;
  logic            r_tx_frame;
  logic            w_run;
  logic            w_accept;
  logic            w_last_pair;

  assign w_run          = (r_state == S_RUN_I) || (r_state == S_RUN_Q);
  assign w_accept       = (r_state == S_IDLE) && start;
  assign w_pair_cnt_inc = r_pair_cnt + CW'(1);
  assign w_last_pair    = (r_burst_pairs != '0) && (w_pair_cnt_inc == r_burst_pairs);

  assign fifo_rinc = w_run && !fifo_rempty;
  assign tx_data   = r_tx_data;
  assign tx_frame  = r_tx_frame;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_END);
  assign underrun  = r_underrun;

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_dly == '0) w_state_nxt = S_RUN_I;
      S_RUN_I:  if (!fifo_rempty) w_state_nxt = S_RUN_Q;
      // The Q slot always closes the pair, popped or not, so stop is only seen here.
      S_RUN_Q:  w_state_nxt = (stop || w_last_pair) ? S_END : S_RUN_I;
      S_END:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      r_burst_pairs <= '0;
      r_pair_cnt    <= '0;
      r_dly         <= '0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_burst_pairs <= burst_pairs;
        r_pair_cnt    <= '0;
        r_dly         <= DLY_LOAD;
        r_underrun    <= 1'b0;
      end else begin
        if ((r_state == S_SETTLE) && (r_dly != '0)) begin
          r_dly <= r_dly - DLYW'(1);
        end
        if (r_state == S_RUN_Q) begin
          r_pair_cnt <= w_pair_cnt_inc;
          if (fifo_rempty) begin
            r_underrun <= 1'b1;
          end
        end
      end
    end
  end

  // FIFO read data lags the pop by one edge; r_pend carries the slot type across.
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      r_pend     <= 1'b0;
      r_pend_i   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_frame <= TX_FRAME_Q;
    end else begin
      r_pend   <= fifo_rinc;
      r_pend_i <= (r_state == S_RUN_I);
      if (r_pend) begin
        r_tx_data  <= fifo_rdata;
        r_tx_frame <= r_pend_i ? TX_FRAME_I : TX_FRAME_Q;
      end else begin
        r_tx_data  <= '0;
        r_tx_frame <= TX_FRAME_Q;
      end
    end
  end

endmodule

// File: tb/tb_jesd207_tx_framer.sv
// Directed bench for jesd207_tx_framer with a small behavioural FIFO model.
module tb_jesd207_tx_framer;

  logic        fclk;
  logic        rstn;
  logic        start;
  logic        stop;
  logic [15:0] burst_pairs;
  logic [11:0] fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic [11:0] tx_data;
  logic        tx_frame;
  logic        busy;
  logic        done;
  logic        underrun;

  logic [11:0] mem [0:63];
  int wr_ptr;
  int rd_ptr;
  int rd0;
  int n_assert;
  int n_fail;

  jesd207_tx_framer #(.DW(12), .CW(16), .START_DLY(2)) dut (
    .fclk        (fclk),
    .rstn        (rstn),
    .start       (start),
    .stop        (stop),
    .burst_pairs (burst_pairs),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .tx_data     (tx_data),
    .tx_frame    (tx_frame),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  initial begin
    rd_ptr     = 0;
    fifo_rdata = '0;
  end

  assign fifo_rempty = (wr_ptr == rd_ptr);

  always @(posedge fclk) begin
    if (fifo_rinc) begin
      fifo_rdata <= mem[rd_ptr % 64];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic push(input logic [11:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input logic [11:0] d, input logic f);
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    chk({tag, "_frame"}, 32'(tx_frame), 32'(f));
  endtask

  task automatic do_start(input logic [15:0] bp);
    burst_pairs = bp;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    wr_ptr = 0;
    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    burst_pairs = '0;
    tick(2);
    chk_tx("rst", 12'h000, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_rinc", 32'(fifo_rinc), 32'd0);
    rstn = 1'b1;
    tick(1);

    // full burst of two pairs
    push(12'hA11); push(12'hB11); push(12'hA12); push(12'hB12);
    chk("idle_rinc_nonempty", 32'(fifo_rinc), 32'd0);
    rd0 = rd_ptr;
    do_start(16'd2);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_settle_rinc", 32'(fifo_rinc), 32'd0);
    tick(1);
    chk("s1_settle2_rinc", 32'(fifo_rinc), 32'd0);
    tick(1);
    chk("s1_first_rinc", 32'(fifo_rinc), 32'd1);
    tick(2);
    chk_tx("s1_w0", 12'hA11, 1'b1);
    tick(1);
    chk_tx("s1_w1", 12'hB11, 1'b0);
    chk("s1_rinc4", 32'(fifo_rinc), 32'd1);
    tick(1);
    chk_tx("s1_w2", 12'hA12, 1'b1);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_end_rinc", 32'(fifo_rinc), 32'd0);
    tick(1);
    chk_tx("s1_w3", 12'hB12, 1'b0);
    chk("s1_done_low", 32'(done), 32'd0);
    chk("s1_busy_low", 32'(busy), 32'd0);
    tick(1);
    chk_tx("s1_after", 12'h000, 1'b0);
    chk("s1_underrun", 32'(underrun), 32'd0);
    chk("s1_pops", 32'(rd_ptr - rd0), 32'd4);

    // Q underrun on the last pair
    push(12'hC11); push(12'hD11); push(12'hC12);
    do_start(16'd2);
    tick(5);
    chk("s2_q_rinc", 32'(fifo_rinc), 32'd0);
    chk("s2_underrun_pre", 32'(underrun), 32'd0);
    tick(1);
    chk_tx("s2_w2", 12'hC12, 1'b1);
    chk("s2_underrun", 32'(underrun), 32'd1);
    chk("s2_done", 32'(done), 32'd1);
    tick(1);
    chk_tx("s2_zero_q", 12'h000, 1'b0);
    tick(3);
    chk("s2_sticky", 32'(underrun), 32'd1);
    chk("s2_busy", 32'(busy), 32'd0);

    // idle words at a pair boundary
    do_start(16'd1);
    chk("s3_clear", 32'(underrun), 32'd0);
    tick(4);
    chk_tx("s3_idle0", 12'h000, 1'b0);
    chk("s3_rinc_empty", 32'(fifo_rinc), 32'd0);
    chk("s3_busy", 32'(busy), 32'd1);
    tick(1);
    chk_tx("s3_idle1", 12'h000, 1'b0);
    push(12'hE11); push(12'hF11);
    tick(1);
    chk_tx("s3_idle2", 12'h000, 1'b0);
    tick(1);
    chk_tx("s3_i", 12'hE11, 1'b1);
    chk("s3_done", 32'(done), 32'd1);
    tick(1);
    chk_tx("s3_q", 12'hF11, 1'b0);
    chk("s3_underrun", 32'(underrun), 32'd0);
    chk("s3_busy_low", 32'(busy), 32'd0);

    // continuous mode, stop raised during an I slot
    for (int i = 0; i < 20; i++) push(12'h400 + 12'(i));
    rd0 = rd_ptr;
    do_start(16'd0);
    tick(6);
    chk_tx("s4_w2", 12'h402, 1'b1);
    stop = 1'b1;
    tick(1);
    chk("s4_no_early_done", 32'(done), 32'd0);
    tick(1);
    chk("s4_done", 32'(done), 32'd1);
    chk_tx("s4_w4", 12'h404, 1'b1);
    stop = 1'b0;
    tick(1);
    chk_tx("s4_w5", 12'h405, 1'b0);
    chk("s4_busy_low", 32'(busy), 32'd0);
    tick(1);
    chk_tx("s4_after", 12'h000, 1'b0);
    chk("s4_pops", 32'(rd_ptr - rd0), 32'd6);

    // start and stop together in IDLE: one pair, then END
    wr_ptr = rd_ptr;
    push(12'h501); push(12'h502); push(12'h503); push(12'h504);
    rd0 = rd_ptr;
    stop = 1'b1;
    do_start(16'd0);
    chk("s4b_busy", 32'(busy), 32'd1);
    tick(4);
    chk("s4b_done", 32'(done), 32'd1);
    chk_tx("s4b_i", 12'h501, 1'b1);
    stop = 1'b0;
    tick(1);
    chk_tx("s4b_q", 12'h502, 1'b0);
    chk("s4b_busy_low", 32'(busy), 32'd0);
    chk("s4b_pops", 32'(rd_ptr - rd0), 32'd2);

    // start while busy is ignored
    wr_ptr = rd_ptr;
    for (int i = 1; i <= 5; i++) push(12'h600 + 12'(i));
    rd0 = rd_ptr;
    do_start(16'd3);
    tick(3);
    burst_pairs = 16'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("s6_no_reload_done", 32'(done), 32'd0);
    chk("s6_busy", 32'(busy), 32'd1);
    tick(2);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_underrun", 32'(underrun), 32'd1);
    chk_tx("s6_w4", 12'h605, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("s6_busy_low", 32'(busy), 32'd0);
    chk("s6_underrun_kept", 32'(underrun), 32'd1);
    chk_tx("s6_zero_q", 12'h000, 1'b0);
    chk("s6_pops", 32'(rd_ptr - rd0), 32'd5);

    // reset mid-burst in RUN_Q
    wr_ptr = rd_ptr;
    for (int i = 1; i <= 6; i++) push(12'h700 + 12'(i));
    do_start(16'd3);
    tick(5);
    chk_tx("s5_pre", 12'h702, 1'b0);
    chk("s5_pre_rinc", 32'(fifo_rinc), 32'd1);
    rstn = 1'b0;
    #1;
    chk_tx("s5_rst", 12'h000, 1'b0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_rinc", 32'(fifo_rinc), 32'd0);
    chk("s5_rst_done", 32'(done), 32'd0);
    tick(1);
    chk_tx("s5_rst_hold", 12'h000, 1'b0);
    rstn = 1'b1;
    wr_ptr = rd_ptr;
    push(12'h801); push(12'h802);
    do_start(16'd1);
    tick(4);
    chk_tx("s5_i", 12'h801, 1'b1);
    chk("s5_done", 32'(done), 32'd1);
    tick(1);
    chk_tx("s5_q", 12'h802, 1'b0);
    chk("s5_busy_low", 32'(busy), 32'd0);
    chk("s5_underrun", 32'(underrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
